// File: rtl/debounce_defs.sv
// debounce_defs: shared state encodings and default parameter values for the
// debounce_pulse pushbutton conditioner.
package debounce_defs;

  // FSM state encodings; the state bit doubles as the debounced level.
  localparam logic ST_REL = 1'b0;
  localparam logic ST_PRS = 1'b1;

  // Default configuration values.
  localparam int DEF_SAMPLES     = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LONG_TICKS  = 8;

endpackage

// File: rtl/sync_rise_tick.sv
// sync_rise_tick: two-flop synchronizer followed by a rising-edge detector.
// A slow level or square wave on d_i becomes a one-cycle tick_o in the clk
// domain, two clk cycles after each rising edge of d_i.
module sync_rise_tick (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic tick_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Synchronize the input, then keep one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      prev_q <= sync_q[1];
    end
  end

  // prev_q resets to 0, so an input already high at reset release gives one tick.
  assign tick_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/debounce_pulse.sv
// debounce_pulse: pushbutton conditioner. The slow sample_clk square wave is
// used purely as a sampling strobe (treated as data, single clk domain). The
// button is synchronized, sampled into a SAMPLES-deep history on each strobe,
// and a two-state FSM produces the debounced level plus one-cycle press and
// release pulses.
// Optional feature macro: DEBOUNCE_LONG_PRESS_EN adds the long_press output,
// which fires once per press after LONG_TICKS strobes of continuous hold.
module debounce_pulse
  import debounce_defs::*;
#(
  parameter int SAMPLES     = DEF_SAMPLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LONG_TICKS  = DEF_LONG_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_clk,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
`ifdef DEBOUNCE_LONG_PRESS_EN
  ,
  output logic long_press
`endif
);

  logic [SYNC_STAGES-1:0] bsync_q;
  logic                   btn_s;
  logic                   tick;
  logic [SAMPLES-1:0]     hist_q, hist_d, hist_shift;
  logic                   state_q, state_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;

  sync_rise_tick u_sc_tick (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sample_clk),
    .tick_o (tick)
  );

  // Synchronize the raw asynchronous button into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bsync_q <= '0;
    else     bsync_q <= {bsync_q[SYNC_STAGES-2:0], btn_in};
  end

  assign btn_s      = bsync_q[SYNC_STAGES-1];
  assign hist_shift = {hist_q[SAMPLES-2:0], btn_s};

  // Sample history and FSM next state; pulses are raised only on the tick edge.
  always_comb begin
    hist_d    = hist_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick) begin
      hist_d = hist_shift;
      if ((state_q == ST_REL) && (&hist_shift)) begin
        state_d = ST_PRS;
        press_d = 1'b1;
      end else if ((state_q == ST_PRS) && (~|hist_shift)) begin
        state_d   = ST_REL;
        release_d = 1'b1;
      end
    end
  end

  // History, state and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q    <= '0;
      state_q   <= ST_REL;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level     = state_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam logic [7:0] LONG_LIM = 8'(LONG_TICKS);

  logic [7:0] hold_q, hold_d;
  logic       long_q, long_d;

  // Count ticks of continuous press; cleared while released, on entry and on release.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (state_q == ST_REL) begin
      hold_d = 8'd0;
    end else if (tick) begin
      if (state_d == ST_REL) begin
        hold_d = 8'd0;
      end else if (hold_q < LONG_LIM) begin
        hold_d = hold_q + 8'd1;
        long_d = ((hold_q + 8'd1) == LONG_LIM);
      end
    end
  end

  // Hold counter and long-press pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= 8'd0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`endif

endmodule

// File: doc/debounce_pulse.md
Name: debounce_pulse

Overview:
- Pushbutton conditioner that consumes the slow square wave from the clock divider as a sampling strobe.
- It cleans one raw button input and emits a debounced level plus single-cycle press and release pulses, all in the fast clk domain.
- It sits between the board button pins and the counter/FSM logic that acts on user input.
- sample_clk is treated as data, never as a clock: one clock domain only.

Parameters:
- SAMPLES, 4, consecutive identical samples needed to change state; legal range 2..16.
- SYNC_STAGES, 2, flops in the btn_in synchronizer; legal range 2..4.
- LONG_TICKS, 8, sample ticks of continuous press before long_press fires; used only with DEBOUNCE_LONG_PRESS_EN; legal range 1..255.

Ports:
- clk  input  1  system clock; all flops on posedge.
- rst  input  1  asynchronous, active-high reset.
- sample_clk  input  1  divided clock from the clock divider; its rising edges are the sample strobe.
- btn_in  input  1  raw, asynchronous, bouncing button.
- btn_level  output  1  debounced button state; 1 = pressed.
- press_pulse  output  1  one clk cycle high on the released->pressed transition.
- release_pulse  output  1  one clk cycle high on the pressed->released transition.
- long_press  output  1  one clk cycle high at the long-press threshold; present only with the macro.

Behaviour:
- Interface fixed: one clock, clk; reset rst is asynchronous and active-high.
- Reset: every flop clears to 0, including synchronizers, sample_clk edge flops, hist, state and all outputs.
  - Reset asserted mid-operation forces all outputs to 0 immediately, with no pulse on entry or exit.
- btn_in passes through SYNC_STAGES flops to give btn_s.
- sample_clk passes through 2 flops (sc_s) plus one delay flop (sc_prev).
  - tick = sc_s & ~sc_prev.
  - tick is high for exactly 1 clk cycle, 2 cycles after each sample_clk rising edge.
  - Because sc_prev resets to 0, sample_clk already high at reset release yields one tick.
- hist: a SAMPLES-bit shift register that updates only on tick: hist_next = {hist[SAMPLES-2:0], btn_s}.
- FSM, 2 states, REL (0) and PRS (1); btn_level equals the state bit.
  - REL -> PRS on a tick edge where hist_next is all ones. At that same edge btn_level<=1 and press_pulse<=1.
  - PRS -> REL on a tick edge where hist_next is all zeros. At that same edge btn_level<=0 and release_pulse<=1.
  - Mixed hist_next: no state change, no pulse.
- press_pulse and release_pulse:
  - Both are registered and return to 0 on the next clk edge.
  - They are never both high.
  - Each transition produces at most one pulse.
- Latency: once btn_s is stable, a state change needs SAMPLES ticks; pulses appear on the edge of the SAMPLES-th tick.
- sample_clk frozen (no ticks): state and outputs hold indefinitely, whatever btn_in does.
- btn_in glitches shorter than one tick period are either not sampled or break the run of identical samples; they never cause a pulse.

Optional Feature:
- Macro: DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - Add an 8-bit hold_cnt, cleared in REL and on entry to PRS, that increments on each tick while in PRS and saturates at LONG_TICKS.
  - long_press pulses for 1 clk on the tick edge where hold_cnt reaches LONG_TICKS, once per press.
  - On release, hold_cnt clears.
- Not defined: the long_press port, hold_cnt and the LONG_TICKS logic are absent. Remaining behaviour is identical.

Decomposition:
- Shared package/header debounce_defs:
  - state encodings ST_REL = 1'b0, ST_PRS = 1'b1;
  - default constants DEF_SAMPLES = 4, DEF_SYNC_STAGES = 2, DEF_LONG_TICKS = 8.
- Sub-module sync_rise_tick (2-flop synchronizer + rising-edge detector giving a 1-cycle tick), instantiated for sample_clk and reusable elsewhere.

Test Plan:
- SAMPLES=4, sample_clk period 10 clk, btn_in steps high cleanly -> press_pulse high exactly 1 cycle, on the edge of the 4th tick after btn_s=1; btn_level=1 from the same edge; release_pulse stays 0.
- btn_in toggles every 7 clk for 80 clk, then holds high -> no pulse during bouncing; exactly one press_pulse after 4 consecutive high ticks.
- From pressed, btn_in drops to 0 -> release_pulse 1 cycle on the 4th low tick; btn_level=0; press_pulse stays 0.
- Hold sample_clk at 0 for 200 clk while toggling btn_in -> btn_level, press_pulse and release_pulse remain unchanged.
- Assert rst for 3 clk while btn_level=1 -> all outputs 0 asynchronously, no release_pulse. With btn_in still high after reset, press_pulse re-fires only after 4 new ticks.
- With DEBOUNCE_LONG_PRESS_EN and LONG_TICKS=8, hold btn_in high for 20 ticks -> long_press pulses once, 8 ticks after the press edge. Release and press again -> it fires again.
